sad_min_search: RTL and testbench
=================================

Name: sad_min_search

Overview:
- Downstream stage of the SAD engine. After the SAD engine signals completion, this block scans the SAD result memory (C memory, NUM_BLOCKS 32-bit entries).
- It finds the minimum SAD value and its block index, then flags whether that minimum is below a programmable threshold.
- It drives the C-memory read port with the same registered address/enable protocol the SAD engine uses on its input memories.
- Its result feeds the motion-vector / match-decision logic.

Parameters:
- NUM_BLOCKS, 128, number of SAD entries scanned (addresses 0..NUM_BLOCKS-1).
- ADDR_W, 7, width of C_Addr; must satisfy 2**ADDR_W >= NUM_BLOCKS.
- DATA_W, 32, width of one SAD entry.

Ports:
- Clk  in  1  single system clock; all state changes on its rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Go  in  1  start a scan; sampled only in IDLE.
- Thresh  in  DATA_W  match threshold; sampled on the final compare cycle.
- C_Addr  out  ADDR_W  C-memory read address.
- C_RW  out  1  C-memory read/write select; always 0 (read).
- C_En  out  1  C-memory enable; high for one cycle per read.
- C_Data  in  DATA_W  C-memory read data; valid 2 cycles after the C_En cycle.
- Busy  out  1  high from the cycle after Go is accepted until Done.
- Done  out  1  one-cycle completion pulse.
- Min_SAD  out  DATA_W  minimum SAD found.
- Min_Idx  out  ADDR_W  index of Min_SAD.
- Match  out  1  Min_SAD < Thresh (strict).

Behaviour:
- Reset (async, any state):
  - State=IDLE.
  - C_Addr, C_En, C_RW, Busy, Done, Match = 0.
  - Min_SAD = 0, Min_Idx = 0, internal count Cnt = 0.
- Defaults: C_Addr, C_En, C_RW and Done are registered outputs, driven 0 every cycle unless the current state sets them.
- IDLE:
  - Go=1 → Cnt<=0, Busy<=1, state ISSUE.
  - Go=0 → stay.
  - Min_SAD, Min_Idx and Match hold their previous values.
- ISSUE: C_Addr<=Cnt, C_En<=1, C_RW<=0, state WAIT.
- WAIT: memory latency cycle; state CMP.
- CMP:
  - If Cnt==0, or C_Data < Min_SAD (unsigned, strict), then Min_SAD<=C_Data and Min_Idx<=Cnt.
  - If Cnt==NUM_BLOCKS-1: Match<=(final minimum < Thresh), Done<=1, Busy<=0, state IDLE.
  - Otherwise: Cnt<=Cnt+1, state ISSUE.
  - The final minimum is C_Data if it updates this cycle, else the held Min_SAD.
- Latency:
  - Let edge 0 be the edge that samples Go=1.
  - Each entry takes 3 cycles.
  - Done is high in the cycle after edge 3*NUM_BLOCKS (after edge 384 with defaults).
  - Min_SAD, Min_Idx and Match are valid when Done is high and held until the next accepted Go.
- Tie rule: strict less-than, so the lowest index holding the minimum wins.
- The first entry is loaded unconditionally, so an all-ones table reports 0xFFFFFFFF at index 0 (no sentinel aliasing).
- Go while Busy is ignored. Go held high continuously restarts a scan in the cycle after Done.
- Go asserted in the same cycle Done is high: accepted, because the state is already IDLE.
- Reset mid-scan: immediate return to reset values. A partial result is never reported and Done does not pulse.
- C_Addr never exceeds NUM_BLOCKS-1. Cnt does not wrap within a scan.
- Arithmetic: unsigned compare only. No subtraction or overflow paths.

Test Plan:
- Memory[i]=1000-i for i=0..127, Go pulse → exactly 128 C_En pulses at addresses 0..127, 3 cycles apart. Done after edge 384; Min_SAD=873, Min_Idx=127.
- Memory[i]=i+5, Thresh=6 → Min_SAD=5, Min_Idx=0, Match=1. Rerun with Thresh=5 → Match=0 (strict).
- Memory all 0x20, except entries 40 and 90 = 0x10 → Min_Idx=40 (lowest index wins), Min_SAD=0x10.
- Memory all 0xFFFFFFFF, Thresh=0xFFFFFFFF → Min_SAD=0xFFFFFFFF, Min_Idx=0, Match=0.
- Go re-pulsed at cycle 50 of a scan → ignored: single Done at edge 384, address sequence undisturbed.
- Rst asserted at cycle 200, released, then new Go → outputs at reset values immediately, no Done from the aborted scan. New scan completes 384 edges after its Go.

Source files
------------

// File: rtl/sad_min_search.sv
`default_nettype none
// ============================================================================
// Module   : sad_min_search
// Purpose  : Scans the SAD result memory for the minimum entry and its index,
//            then flags whether that minimum is below a threshold.
// Revision : 1.0 - initial release
// ============================================================================
module sad_min_search #(
  parameter int NUM_BLOCKS = 128,
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Go,
  input  logic [DATA_W-1:0] Thresh,
  output logic [ADDR_W-1:0] C_Addr,
  output logic              C_RW,
  output logic              C_En,
  input  logic [DATA_W-1:0] C_Data,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] Min_SAD,
  output logic [ADDR_W-1:0] Min_Idx,
  output logic              Match
);

  localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_CMP   = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;

  logic              w_upd;
  logic [DATA_W-1:0] w_final;

  // Entry 0 loads unconditionally so no sentinel value is ever needed.
  assign w_upd   = (r_cnt == '0) || (C_Data < Min_SAD);
  assign w_final = w_upd ? C_Data : Min_SAD;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      C_Addr  <= '0;
      C_En    <= 1'b0;
      C_RW    <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Min_SAD <= '0;
      Min_Idx <= '0;
      Match   <= 1'b0;
    end else begin
      C_Addr <= '0;
      C_En   <= 1'b0;
      C_RW   <= 1'b0;
      Done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Go) begin
            r_cnt   <= '0;
            Busy    <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          C_Addr  <= r_cnt;
          C_En    <= 1'b1;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_state <= S_CMP;
        end
        S_CMP: begin
          if (w_upd) begin
            Min_SAD <= C_Data;
            Min_Idx <= r_cnt;
          end
          if (r_cnt == c_LAST) begin
            Match   <= (w_final < Thresh);
            Done    <= 1'b1;
            Busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= r_cnt + ADDR_W'(1);
            r_state <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sad_min_search.sv
`default_nettype none
// ============================================================================
// Module   : tb_sad_min_search
// Purpose  : Self-checking bench for sad_min_search with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sad_min_search;

  localparam int N  = 128;
  localparam int AW = 7;
  localparam int DW = 32;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Go;
  logic [DW-1:0] Thresh;
  logic [AW-1:0] C_Addr;
  logic          C_RW;
  logic          C_En;
  logic [DW-1:0] C_Data = '0;
  logic          Busy;
  logic          Done;
  logic [DW-1:0] Min_SAD;
  logic [AW-1:0] Min_Idx;
  logic          Match;

  logic [DW-1:0] mem [N];

  int n_checks = 0;
  int n_fail   = 0;

  sad_min_search #(.NUM_BLOCKS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Rst(Rst), .Go(Go), .Thresh(Thresh),
    .C_Addr(C_Addr), .C_RW(C_RW), .C_En(C_En), .C_Data(C_Data),
    .Busy(Busy), .Done(Done), .Min_SAD(Min_SAD), .Min_Idx(Min_Idx),
    .Match(Match)
  );

  always #5 Clk = ~Clk;

  // Synchronous memory: data held until the next enabled read.
  always @(posedge Clk) if (C_En) C_Data <= mem[C_Addr];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Minimum value first, then the first index holding it.
  task automatic ref_result(input logic [DW-1:0] th, output logic [DW-1:0] m,
                            output logic [AW-1:0] idx, output logic mt);
    longint unsigned best = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < N; i++)
      if (longint'(mem[i]) < best) best = longint'(mem[i]);
    m = DW'(best);
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (mem[i] == m) idx = AW'(i);
    mt = (m < th);
  endtask

  task automatic run_scan(input string name, input logic [DW-1:0] th, input int regoat);
    int e = 0, n_en = 0, n_done = 0, done_edge = -1;
    bit seq_ok = 1, rw_ok = 1;
    logic [DW-1:0] em;
    logic [AW-1:0] ei;
    logic          emt;
    @(negedge Clk);
    Thresh = th;
    Go = 1'b1;
    @(posedge Clk);
    #1 Go = 1'b0;
    check({name, "_busy_start"}, Busy, 1);
    while (e < 3 * N + 10) begin
      @(posedge Clk);
      e++;
      #1;
      if (Go) Go = 1'b0;
      if (C_RW) rw_ok = 0;
      if (C_En) begin
        if (C_Addr != AW'(n_en) || e != 3 * n_en + 1) seq_ok = 0;
        n_en++;
      end
      if (Done) begin
        n_done++;
        done_edge = e;
      end
      if (e == regoat) Go = 1'b1;
    end
    ref_result(th, em, ei, emt);
    check({name, "_n_en"}, n_en, N);
    check({name, "_addr_seq"}, seq_ok, 1);
    check({name, "_rw"}, rw_ok, 1);
    check({name, "_n_done"}, n_done, 1);
    check({name, "_done_edge"}, done_edge, 3 * N);
    check({name, "_busy_end"}, Busy, 0);
    check({name, "_min"}, Min_SAD, em);
    check({name, "_idx"}, Min_Idx, ei);
    check({name, "_match"}, Match, emt);
  endtask

  initial begin
    Rst = 1'b1;
    Go = 1'b0;
    Thresh = '0;
    for (int i = 0; i < N; i++) mem[i] = '0;
    #12;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_en", C_En, 0);
    check("rst_addr", C_Addr, 0);
    check("rst_min", Min_SAD, 0);
    check("rst_idx", Min_Idx, 0);
    check("rst_match", Match, 0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < N; i++) mem[i] = DW'(1000 - i);
    run_scan("desc", 32'd0, -1);
    check("desc_min_const", Min_SAD, 873);
    check("desc_idx_const", Min_Idx, 127);

    for (int i = 0; i < N; i++) mem[i] = DW'(i + 5);
    run_scan("inc_t6", 32'd6, -1);
    check("inc_t6_match_const", Match, 1);
    run_scan("inc_t5", 32'd5, -1);
    check("inc_t5_match_const", Match, 0);

    for (int i = 0; i < N; i++) mem[i] = 32'h20;
    mem[40] = 32'h10;
    mem[90] = 32'h10;
    run_scan("tie", 32'h11, -1);
    check("tie_idx_const", Min_Idx, 40);

    for (int i = 0; i < N; i++) mem[i] = 32'hFFFF_FFFF;
    run_scan("ones", 32'hFFFF_FFFF, -1);
    check("ones_min_const", Min_SAD, 32'hFFFF_FFFF);

    for (int i = 0; i < N; i++) mem[i] = $urandom;
    run_scan("rnd_rego", $urandom, 50);

    for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(3, 40));
    run_scan("rnd_small", DW'($urandom_range(0, 8)), -1);

    for (int i = 0; i < N; i++) mem[i] = 32'h0001_0000 + DW'($urandom_range(0, 4095));
    @(negedge Clk);
    Go = 1'b1;
    @(posedge Clk);
    #1 Go = 1'b0;
    repeat (200) @(posedge Clk);
    #1 Rst = 1'b1;
    #1;
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_en", C_En, 0);
    check("mid_rst_min", Min_SAD, 0);
    check("mid_rst_idx", Min_Idx, 0);
    check("mid_rst_match", Match, 0);
    begin
      int dcnt = 0;
      repeat (3) begin
        @(posedge Clk);
        #1 if (Done) dcnt++;
      end
      @(negedge Clk);
      Rst = 1'b0;
      repeat (200) begin
        @(posedge Clk);
        #1 if (Done) dcnt++;
      end
      check("mid_rst_no_done", dcnt, 0);
    end
    run_scan("post_rst", 32'h0001_0800, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
